// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a DIGITS-wide 7-segment display that
//   shares one BCD-to-7-segment decoder. One digit is presented at a time on
//   bcd_out while its common line is enabled through one-hot digit_en. Each
//   digit is shown for DIV cycles, followed by GAP cycles of all-off dead time.
//   New values arrive through a valid/ready handshake into a shadow register
//   and are only copied into the displayed value at a frame boundary (or at
//   once while the display is off), so a frame is never torn.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; low forces the display off
//   lz_en      leading-zero suppression enable
//   upd_valid  new display value offered
//   upd_data   new value, digit i at [4i+3:4i]
//   upd_ready  shadow register free (= ~pending)
//   upd_done   one-cycle pulse when a pending value becomes the displayed value
//   bcd_out    digit code to the decoder; 4'hF = blank
//   digit_en   one-hot digit enable; all zero when off or in the gap
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 4,
    parameter int GAP    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  lz_en,
    input  logic                  upd_valid,
    input  logic [4*DIGITS-1:0]   upd_data,
    output logic                  upd_ready,
    output logic                  upd_done,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int CMAX  = (DIV > GAP) ? DIV : GAP;
    localparam int CMAX2 = (CMAX > 2) ? CMAX : 2;
    localparam int CW    = $clog2(CMAX2);
    localparam int IW    = $clog2(DIGITS);
    localparam int GAP_L = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [CW-1:0]     DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]     GAP_LAST = CW'(GAP_L);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_GAP
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [4*DIGITS-1:0] disp, disp_nxt;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic                apply;
    logic                adv;

    // Displayed code for digit i: blank when suppression is on and this digit
    // and everything above it is zero. Digit 0 always shows.
    function automatic logic [3:0] eff(input logic [4*DIGITS-1:0] v,
                                       input logic [IW-1:0]       i,
                                       input logic                lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(i) && v[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (lz && i != '0 && upper_zero) return 4'hF;
        return v[4*int'(i) +: 4];
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        apply     = 1'b0;
        adv       = 1'b0;

        if (!en) begin
            state_nxt = ST_OFF;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            // While parked in OFF nothing is on screen, so a pending value
            // can be taken over without waiting for a frame boundary.
            apply     = (state == ST_OFF) && pending;
        end else begin
            case (state)
                ST_OFF: begin
                    apply     = pending;
                    state_nxt = ST_SHOW;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                ST_SHOW: begin
                    if (cnt == DIV_LAST) begin
                        if (GAP > 0) begin
                            state_nxt = ST_GAP;
                            cnt_nxt   = '0;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) adv = 1'b1;
                    else                 cnt_nxt = cnt + 1'b1;
                end
                default: state_nxt = ST_OFF;
            endcase
        end

        if (adv) begin
            state_nxt = ST_SHOW;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
                // Frame boundary: the only point a running display swaps value.
                idx_nxt = '0;
                apply   = pending;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end

        disp_nxt = apply ? shadow : disp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            idx      <= '0;
            cnt      <= '0;
            disp     <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            upd_done <= 1'b0;
            digit_en <= '0;
            bcd_out  <= 4'hF;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            disp     <= disp_nxt;
            upd_done <= apply;
            // apply implies pending was set, so no transfer can collide with it.
            if (apply) begin
                pending <= 1'b0;
            end else if (upd_valid && !pending) begin
                pending <= 1'b1;
                shadow  <= upd_data;
            end
            // Outputs follow the state being entered so they line up with it.
            if (state_nxt == ST_SHOW) begin
                digit_en <= ONE_HOT0 << idx_nxt;
                bcd_out  <= eff(disp_nxt, idx_nxt, lz_en);
            end else begin
                digit_en <= '0;
                bcd_out  <= 4'hF;
            end
        end
    end

    assign upd_ready = ~pending;

endmodule
